// File: rtl/chacha_block_iter.sv
// Iterative ChaCha block function: QR_PER_CYCLE quarterround lanes reused over
// ROUNDS rounds, followed by the feed-forward addition of the initial state.
module chacha_block_iter #(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [63:0]  ctr,
  input  logic [63:0]  nonce,
  output logic         ready,
  output logic         out_valid,
  input  logic         out_ack,
  output logic [511:0] block_out
);

  localparam int K          = ROUNDS * 4 / QR_PER_CYCLE;
  localparam int STEP_W     = $clog2(K);
  localparam int HALF_STEPS = 4 / QR_PER_CYCLE;

  generate
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
      $error("chacha_block_iter: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qr
      $error("chacha_block_iter: QR_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t             state, state_next;
  logic [15:0][31:0]  work, work_next, init_st, init_words;
  logic [STEP_W-1:0]  step_cnt;
  logic               last_step;
  logic [511:0]       sum_flat;
  int                 pos, grp;
  logic               diag;
  logic [1:0]         q;
  logic [3:0]         ia, ib, ic, id;
  logic [127:0]       qr_res;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarterround(input logic [31:0] a_i, input logic [31:0] b_i,
                                                input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Word 0 is the least significant packed element; constants occupy words 0-3.
  assign init_words = {nonce, ctr,
                       key[31:0],    key[63:32],   key[95:64],   key[127:96],
                       key[159:128], key[191:160], key[223:192], key[255:224],
                       32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  assign last_step = (step_cnt == STEP_W'(K - 1));

  // The step index selects column vs diagonal half and which group of QRs runs now.
  always_comb begin
    work_next = work;
    pos       = int'(step_cnt) % (2 * HALF_STEPS);
    diag      = (pos >= HALF_STEPS);
    grp       = pos % HALF_STEPS;
    q         = '0;
    ia        = '0;
    ib        = '0;
    ic        = '0;
    id        = '0;
    qr_res    = '0;
    for (int j = 0; j < QR_PER_CYCLE; j++) begin
      q  = 2'(grp * QR_PER_CYCLE + j);
      ia = {2'b00, q};
      ib = diag ? {2'b01, q + 2'd1} : {2'b01, q};
      ic = diag ? {2'b10, q + 2'd2} : {2'b10, q};
      id = diag ? {2'b11, q + 2'd3} : {2'b11, q};
      qr_res = quarterround(work[ia], work[ib], work[ic], work[id]);
      work_next[ia] = qr_res[127:96];
      work_next[ib] = qr_res[95:64];
      work_next[ic] = qr_res[63:32];
      work_next[id] = qr_res[31:0];
    end
  end

  always_comb begin
    sum_flat = '0;
    for (int i = 0; i < 16; i++) begin
      sum_flat[511 - 32*i -: 32] = work[i] + init_st[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = ROUND;
      end
      ROUND: if (last_step) state_next = FINAL;
      FINAL: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // block_out is only rewritten in FINAL, so it survives the ack until the next block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work      <= '0;
      init_st   <= '0;
      step_cnt  <= '0;
      block_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work     <= init_words;
            init_st  <= init_words;
            step_cnt <= '0;
          end
        end
        ROUND: begin
          work     <= work_next;
          step_cnt <= step_cnt + STEP_W'(1);
        end
        FINAL: block_out <= sum_flat;
        default: ;
      endcase
    end
  end

endmodule
